cell_mem_arb: RTL and testbench
===============================

CELL_MEM_ARB -- requirements
Module: cell_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 13: cell-memory address width.
REQ-002 Parameter DATA_W, default 8: cell-memory word width.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 vga_req  in  1  scanout read request, highest priority, never stalled.
REQ-006 vga_addr  in  ADDR_W  scanout read address.
REQ-007 vga_rdata  out  DATA_W  scanout read data; vga_rvalid  out  1  data valid.
REQ-008 eng_req, eng_we  in  1 each  Life-engine request and write flag.
REQ-009 eng_addr  in  ADDR_W; eng_wdata  in  DATA_W  engine address and write data.
REQ-010 eng_gnt  out  1; eng_rdata  out  DATA_W; eng_rvalid  out  1  engine grant, read data, valid.
REQ-011 uart_req, uart_we, uart_addr, uart_wdata, uart_gnt, uart_rdata, uart_rvalid: same widths and meaning as engine port, for the UART loader.
REQ-012 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  single-port RAM command.
REQ-013 mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_en with mem_we=0.

Function
REQ-014 Per cycle at most one requester SHALL drive mem_en; priority vga > round-robin(eng, uart).
REQ-015 vga_req high SHALL drive mem_en=1, mem_we=0, mem_addr=vga_addr same cycle; eng_gnt=uart_gnt=0 that cycle.
REQ-016 Without vga_req, a single requesting port SHALL be granted combinationally same cycle.
REQ-017 With eng_req and uart_req both high and no vga_req, grant SHALL go to the port not granted last; 1-bit last-winner register SHALL update only on a granted eng/uart cycle.
REQ-018 Requesters SHALL hold req, we, addr, wdata stable until gnt is sampled high; one access per gnt cycle.
REQ-019 Granted write SHALL drive mem_we=1, mem_wdata from owner; no rvalid generated.
REQ-020 Granted read SHALL assert that port's rvalid exactly 1 cycle later with rdata=mem_rdata; registered owner tag steers it.
REQ-021 rvalid SHALL be a 1-cycle pulse; rdata outputs SHALL hold last value when rvalid low.
REQ-022 Idle cycle (no req) SHALL drive mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care.
REQ-023 Back-to-back reads from one port SHALL sustain 1 access/cycle when uncontested.
REQ-024 Write then read same address in consecutive cycles SHALL return new data (RAM write-first assumed by contract).

Reset
REQ-025 rst SHALL clear last-winner to uart (engine wins first tie), clear owner tag, force all rvalid=0, rdata=0.
REQ-026 Read issued in the cycle rst is asserted SHALL produce no rvalid; gnt outputs SHALL be 0 while rst high.
REQ-027 mem_en and mem_we SHALL be 0 while rst high.

Configuration
REQ-028 Macro CELL_MEM_ARB_STALL_CNT_EN defined: output stall_cnt  out  16, counts cycles where eng_req or uart_req is high and not granted; saturates at 16'hFFFF; cleared by rst.
REQ-029 Macro undefined: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 eng read addr 0x010, uart idle, vga idle -> eng_gnt=1 same cycle, eng_rvalid=1 next cycle with RAM[0x010].
REQ-031 vga_req held 4 cycles with eng_req and uart_req high -> no gnt for 4 cycles, 4 vga_rvalid pulses, stall_cnt=4 (macro on).
REQ-032 eng and uart both requesting continuously from reset -> grants alternate eng, uart, eng, uart.
REQ-033 uart write 0xA5 to 0x1FFF, then eng read 0x1FFF next cycle -> eng_rdata=0xA5.
REQ-034 rst asserted in cycle eng read granted -> no eng_rvalid next cycle; after release, first tie goes to eng.
REQ-035 stall_cnt forced near 0xFFFE with 5 contested cycles -> stays 0xFFFF (macro on); port absent with macro off.

Source files
------------

// File: rtl/cell_mem_arb.sv
// Cell-memory arbiter: VGA scanout has absolute priority, engine and UART loader share the rest round-robin.
// Optional saturating stall counter enabled by defining CELL_MEM_ARB_STALL_CNT_EN.
module cell_mem_arb #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CELL_MEM_ARB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic              uart_gnt,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VGA  = 2'd1;
  localparam logic [1:0] OWN_ENG  = 2'd2;
  localparam logic [1:0] OWN_UART = 2'd3;

  logic              last_eng;
  logic [1:0]        owner_q;
  logic [1:0]        owner_nxt;
  logic              vga_sel;
  logic              eng_sel;
  logic              uart_sel;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] eng_rdata_q;
  logic [DATA_W-1:0] uart_rdata_q;

  // Grant selection; last_eng low means the engine wins the next tie
  always_comb begin
    vga_sel   = 1'b0;
    eng_sel   = 1'b0;
    uart_sel  = 1'b0;
    owner_nxt = OWN_NONE;
    if (!rst) begin
      if (vga_req) begin
        vga_sel = 1'b1;
      end else if (eng_req && (!uart_req || !last_eng)) begin
        eng_sel = 1'b1;
      end else if (uart_req) begin
        uart_sel = 1'b1;
      end
    end
    if (vga_sel) begin
      owner_nxt = OWN_VGA;
    end else if (eng_sel && !eng_we) begin
      owner_nxt = OWN_ENG;
    end else if (uart_sel && !uart_we) begin
      owner_nxt = OWN_UART;
    end
  end

  assign eng_gnt   = eng_sel;
  assign uart_gnt  = uart_sel;
  assign mem_en    = vga_sel | eng_sel | uart_sel;
  assign mem_we    = (eng_sel & eng_we) | (uart_sel & uart_we);
  assign mem_addr  = vga_sel ? vga_addr : (uart_sel ? uart_addr : eng_addr);
  assign mem_wdata = uart_sel ? uart_wdata : eng_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_eng     <= 1'b0;
      owner_q      <= OWN_NONE;
      vga_rdata_q  <= '0;
      eng_rdata_q  <= '0;
      uart_rdata_q <= '0;
    end else begin
      if (eng_sel) begin
        last_eng <= 1'b1;
      end else if (uart_sel) begin
        last_eng <= 1'b0;
      end
      owner_q <= owner_nxt;
      if (owner_q == OWN_VGA)  vga_rdata_q  <= mem_rdata;
      if (owner_q == OWN_ENG)  eng_rdata_q  <= mem_rdata;
      if (owner_q == OWN_UART) uart_rdata_q <= mem_rdata;
    end
  end

  // RAM data arrives one cycle after the grant; the owner tag steers it, holding registers keep it
  assign vga_rvalid  = !rst && (owner_q == OWN_VGA);
  assign eng_rvalid  = !rst && (owner_q == OWN_ENG);
  assign uart_rvalid = !rst && (owner_q == OWN_UART);
  assign vga_rdata   = vga_rvalid  ? mem_rdata : vga_rdata_q;
  assign eng_rdata   = eng_rvalid  ? mem_rdata : eng_rdata_q;
  assign uart_rdata  = uart_rvalid ? mem_rdata : uart_rdata_q;

`ifdef CELL_MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stalled;

  assign stalled = (eng_req && !eng_sel) || (uart_req && !uart_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stalled && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cell_mem_arb.sv
// Randomized scoreboard bench for cell_mem_arb with a RAM model and a spec-level arbitration model.
module tb_cell_mem_arb;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          eng_req = 1'b0, eng_we = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic [DW-1:0] eng_wdata = '0;
  logic          eng_gnt;
  logic [DW-1:0] eng_rdata;
  logic          eng_rvalid;
  logic          uart_req = 1'b0, uart_we = 1'b0;
  logic [AW-1:0] uart_addr = '0;
  logic [DW-1:0] uart_wdata = '0;
  logic          uart_gnt;
  logic [DW-1:0] uart_rdata;
  logic          uart_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef CELL_MEM_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   exp_stall = '0;
`endif

  cell_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
`ifdef CELL_MEM_ARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_gnt(uart_gnt), .uart_rdata(uart_rdata), .uart_rvalid(uart_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 37 + 11) ^ DW'(a >> 5);
  endfunction

  // Synchronous single-port RAM, write-first by construction (one access per cycle)
  logic [DW-1:0] ram [DEPTH];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] = init_val(i);
      ram_ready = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Reference state: 0=vga, 1=eng, 2=uart
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [3][$];
  logic [DW-1:0] last_d [3];
  bit            eng_won_last = 1'b0;
  bit            pend_v [3];
  logic [DW-1:0] pend_d [3];
  bit            stall_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever a port presents rvalid, otherwise checks rdata holds
  always @(negedge clk) begin
    logic [2:0]    rv;
    logic [DW-1:0] rd [3];
    logic [DW-1:0] e;
    rv = {uart_rvalid, eng_rvalid, vga_rvalid};
    rd[0] = vga_rdata; rd[1] = eng_rdata; rd[2] = uart_rdata;
    if (rst) begin
      chk("rvalid_in_rst", 32'(rv), 32'd0);
      for (int p = 0; p < 3; p++) last_d[p] = '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (rv[p]) begin
          if (exp_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid port=%0d actual=1 required=0 at %0t", p, $time);
          end else begin
            e = exp_q[p].pop_front();
            chk($sformatf("rdata_p%0d", p), 32'(rd[p]), 32'(e));
            last_d[p] = e;
          end
        end else begin
          chk($sformatf("rdata_hold_p%0d", p), 32'(rd[p]), 32'(last_d[p]));
        end
      end
    end
  end

  // One bus cycle: drive, retire last cycle's reads, predict grants, compare, update reference
  task automatic cycle(input bit r, input bit vq, input logic [AW-1:0] va,
                       input bit eq, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input bit uq, input bit uw, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                       output bit eg, output bit ug);
    bit vs, es, us;
    @(posedge clk);
    #1;
    rst = r; vga_req = vq; vga_addr = va;
    eng_req = eq; eng_we = ew; eng_addr = ea; eng_wdata = ed;
    uart_req = uq; uart_we = uw; uart_addr = ua; uart_wdata = ud;
    #1;
    for (int p = 0; p < 3; p++) begin
      if (!r && pend_v[p]) exp_q[p].push_back(pend_d[p]);
      pend_v[p] = 1'b0;
    end
    vs = 1'b0; es = 1'b0; us = 1'b0;
    if (r) eng_won_last = 1'b0;
    else if (vq) vs = 1'b1;
    else if (eq && uq) begin
      if (eng_won_last) us = 1'b1; else es = 1'b1;
    end else if (eq) es = 1'b1;
    else if (uq) us = 1'b1;
    if (es) eng_won_last = 1'b1;
    if (us) eng_won_last = 1'b0;
`ifdef CELL_MEM_ARB_STALL_CNT_EN
    if (stall_known) chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    if (r) exp_stall = '0;
    else if (((eq && !es) || (uq && !us)) && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
    if (r) stall_known = 1'b1;
    chk("eng_gnt", 32'(eng_gnt), 32'(es));
    chk("uart_gnt", 32'(uart_gnt), 32'(us));
    chk("mem_en", 32'(mem_en), 32'(vs | es | us));
    chk("mem_we", 32'(mem_we), 32'((es && ew) || (us && uw)));
    if (vs) chk("mem_addr_vga", 32'(mem_addr), 32'(va));
    if (es) chk("mem_addr_eng", 32'(mem_addr), 32'(ea));
    if (us) chk("mem_addr_uart", 32'(mem_addr), 32'(ua));
    if (es && ew) begin
      chk("mem_wdata_eng", 32'(mem_wdata), 32'(ed));
      ref_mem[ea] = ed;
    end
    if (us && uw) begin
      chk("mem_wdata_uart", 32'(mem_wdata), 32'(ud));
      ref_mem[ua] = ud;
    end
    pend_v[0] = vs;          pend_d[0] = ref_mem[va];
    pend_v[1] = es && !ew;   pend_d[1] = ref_mem[ea];
    pend_v[2] = us && !uw;   pend_d[2] = ref_mem[ua];
    eg = es; ug = us;
  endtask

  task automatic idle(input bit r);
    bit eg, ug;
    cycle(r, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, eg, ug);
  endtask

  initial begin
    bit eg, ug;
    bit            e_q, e_w, u_q, u_w;
    logic [AW-1:0] e_a, u_a;
    logic [DW-1:0] e_d, u_d;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 3; p++) begin last_d[p] = '0; pend_v[p] = 1'b0; pend_d[p] = '0; end

    idle(1'b1);
    idle(1'b1);
    chk("rst_eng_rdata", 32'(eng_rdata), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    idle(1'b0);
    chk("post_rst_rdata", 32'({vga_rdata, eng_rdata, uart_rdata}), 32'd0);

    // Single engine read of 0x010
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 13'h010, '0, 1'b0, 1'b0, '0, '0, eg, ug);
    chk("single_eng_gnt", 32'(eng_gnt), 32'd1);
    idle(1'b0);
    chk("single_eng_rvalid", 32'(eng_rvalid), 32'd1);
    chk("single_eng_rdata", 32'(eng_rdata), 32'(init_val(16)));

    // Continuous tie right after reset alternates starting with engine
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(100 + i), '0, eg, ug);
      chk("alt_eng_gnt", 32'(eng_gnt), 32'(i % 2 == 0));
      chk("alt_uart_gnt", 32'(uart_gnt), 32'(i % 2 == 1));
    end

    // VGA held 4 cycles blocks both contenders
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, AW'(200 + i), 1'b1, 1'b0, 13'h20, '0, 1'b1, 1'b0, 13'h30, '0, eg, ug);
      chk("vga_block", 32'({eng_gnt, uart_gnt}), 32'd0);
    end
    idle(1'b0);
`ifdef CELL_MEM_ARB_STALL_CNT_EN
    chk("stall_after_vga", 32'(stall_cnt), 32'd4);
`endif

    // UART writes 0xA5 to top address, engine reads it next cycle
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'h1FFF, 8'hA5, eg, ug);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 13'h1FFF, '0, 1'b0, 1'b0, '0, '0, eg, ug);
    idle(1'b0);
    chk("wr_then_rd", 32'(eng_rdata), 32'hA5);

    // Reset during an engine read: no grant, no response, next tie to engine
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 13'h010, '0, 1'b0, 1'b0, '0, '0, eg, ug);
    chk("rst_no_gnt", 32'(eng_gnt), 32'd0);
    idle(1'b0);
    chk("rst_no_rvalid", 32'(eng_rvalid), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 13'h5, '0, 1'b1, 1'b0, 13'h6, '0, eg, ug);
    chk("rst_first_tie", 32'(eng_gnt), 32'd1);

`ifdef CELL_MEM_ARB_STALL_CNT_EN
    idle(1'b0);
    force dut.stall_q = 16'hFFFE;
    release dut.stall_q;
    exp_stall = 16'hFFFE;
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, eg, ug);
    idle(1'b0);
    chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
`endif

    // Randomized traffic; requesters hold their request until granted
    e_q = 1'b0; u_q = 1'b0;
    e_w = 1'b0; u_w = 1'b0; e_a = '0; u_a = '0; e_d = '0; u_d = '0;
    for (int n = 0; n < 3000; n++) begin
      bit r, vq;
      logic [AW-1:0] va;
      r  = ($urandom_range(0, 199) == 0);
      vq = ($urandom_range(0, 3) == 0);
      va = AW'($urandom());
      if (!e_q && $urandom_range(0, 2) != 0) begin
        e_q = 1'b1; e_w = $urandom_range(0, 1) == 1; e_d = DW'($urandom());
        e_a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom());
      end
      if (!u_q && $urandom_range(0, 2) != 0) begin
        u_q = 1'b1; u_w = $urandom_range(0, 1) == 1; u_d = DW'($urandom());
        u_a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom());
      end
      cycle(r, vq, va, e_q, e_w, e_a, e_d, u_q, u_w, u_a, u_d, eg, ug);
      if (eg) e_q = 1'b0;
      if (ug) u_q = 1'b0;
    end

    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    for (int p = 0; p < 3; p++) chk($sformatf("queue_empty_p%0d", p), 32'(exp_q[p].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
